// File: rtl/mips_bus_master.sv
// mips_bus_master: single-outstanding load/store initiator for the MIPS core's
// memory port on an Avalon-style bus. It handles waitrequest stalls, byte-lane
// steering, byteenable generation and sign/zero extension of load data.
module mips_bus_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [1:0]  core_size,
  input  logic        core_signed,
  input  logic [31:0] core_wdata,
  output logic        core_busy,
  output logic        core_done,
  output logic        core_err,
  output logic [31:0] core_rdata,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_BUS  = 3'd1;
  localparam logic [2:0] S_RLAT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]  state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  off_q;

  logic        misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wd;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;

  // Request decode: alignment check, byteenable and lane-steered store data
  always_comb begin
    misaligned = 1'b0;
    req_be     = 4'b1111;
    req_wd     = core_wdata;
    case (core_size)
      2'b00: begin
        req_be = 4'b0001 << core_addr[1:0];
        req_wd = {4{core_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = core_addr[0];
        req_be     = core_addr[1] ? 4'b1100 : 4'b0011;
        req_wd     = {2{core_wdata[15:0]}};
      end
      default: begin
        misaligned = (core_addr[1:0] != 2'b00);
      end
    endcase
  end

  // Load extraction: right-justify the addressed lane and extend it
  always_comb begin
    case (off_q)
      2'd0:    sel_byte = readdata[7:0];
      2'd1:    sel_byte = readdata[15:8];
      2'd2:    sel_byte = readdata[23:16];
      default: sel_byte = readdata[31:24];
    endcase
    sel_half = off_q[1] ? readdata[31:16] : readdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & sel_byte[7]}}, sel_byte};
      2'b01:   load_ext = {{16{signed_q & sel_half[15]}}, sel_half};
      default: load_ext = readdata;
    endcase
  end

  // Transfer sequencing and registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      core_rdata <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      off_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (core_req) begin
            if (misaligned) begin
              state <= S_ERR;
            end else begin
              state      <= S_BUS;
              address    <= {core_addr[31:2], 2'b00};
              byteenable <= req_be;
              writedata  <= req_wd;
              write      <= core_we;
              read       <= ~core_we;
              we_q       <= core_we;
              size_q     <= core_size;
              signed_q   <= core_signed;
              off_q      <= core_addr[1:0];
            end
          end
        end
        S_BUS: begin
          if (!waitrequest) begin
            read  <= 1'b0;
            write <= 1'b0;
            state <= we_q ? S_DONE : S_RLAT;
          end
        end
        S_RLAT: begin
          core_rdata <= load_ext;
          state      <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign core_done = (state == S_DONE) || (state == S_ERR);
  assign core_err  = (state == S_ERR);
  assign core_busy = (state == S_BUS) || (state == S_RLAT) || (state == S_DONE);

endmodule

// File: tb/tb_mips_bus_master.sv
// Testbench for mips_bus_master: a bus slave memory with programmable stalls,
// and a reference model of memory contents and expected transaction results.
module tb_mips_bus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        core_req = 1'b0;
  logic        core_we = 1'b0;
  logic [31:0] core_addr = '0;
  logic [1:0]  core_size = '0;
  logic        core_signed = 1'b0;
  logic [31:0] core_wdata = '0;
  logic        core_busy, core_done, core_err;
  logic [31:0] core_rdata, address, writedata, readdata;
  logic        write, read, waitrequest;
  logic [3:0]  byteenable;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  logic [31:0] last_rdata = '0;
  int          stall_cfg = 0;
  int          stall_cnt = 0;

  mips_bus_master dut (
    .clk(clk), .reset(reset), .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_size(core_size), .core_signed(core_signed),
    .core_wdata(core_wdata), .core_busy(core_busy), .core_done(core_done),
    .core_err(core_err), .core_rdata(core_rdata), .address(address),
    .write(write), .read(read), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;

  // Slave: stalls each strobe for stall_cfg cycles, read data one cycle later
  assign waitrequest = (read || write) && (stall_cnt < stall_cfg);

  always @(posedge clk) begin
    if (!(read || write)) stall_cnt <= 0;
    else if (waitrequest) stall_cnt <= stall_cnt + 1;
    if (read && !waitrequest) readdata <= mem[address[5:2]];
    else readdata <= $urandom;
    if (write && !waitrequest) begin
      for (int k = 0; k < 4; k++)
        if (byteenable[k]) mem[address[5:2]][8*k +: 8] <= writedata[8*k +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  // One core transaction, checked against the reference memory model
  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [1:0] size,
                        input bit sgn, input logic [31:0] wd, input int stalls);
    int n, off, sh, lat, got_lat, strobes;
    bit mis, seen;
    logic [31:0] mask, data_exp, be_exp, w, v;
    n   = nbytes(size);
    off = int'(addr[1:0]);
    mis = (off % n) != 0;
    sh  = 8 * off;
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    be_exp = ((32'd1 << n) - 32'd1) << off;
    data_exp = '0;
    for (int k = 0; k < 4; k++) data_exp[8*k +: 8] = wd[8*(k % n) +: 8];
    lat = mis ? 1 : (we ? 2 : 3) + stalls;

    @(negedge clk);
    stall_cfg = stalls;
    core_req = 1'b1; core_we = we; core_addr = addr; core_size = size;
    core_signed = sgn; core_wdata = wd;
    @(posedge clk);
    #1 core_req = 1'b0;

    seen = 0; got_lat = 0; strobes = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (read && write) chk("rw_exclusive", 32'd1, 32'd0);
      if (read || write) begin
        strobes++;
        chk("address", address, {addr[31:2], 2'b00});
        chk("byteenable", 32'(byteenable), be_exp);
        chk("strobe_kind", {30'b0, write, read}, we ? 32'd2 : 32'd1);
        if (we) chk("writedata", writedata, data_exp);
      end
      if (core_done) begin
        got_lat = k; seen = 1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    chk("latency", 32'(got_lat), 32'(lat));
    chk("core_err", 32'(core_err), 32'(mis));
    chk("busy_at_done", 32'(core_busy), 32'(!mis));
    chk("strobe_cycles", 32'(strobes), mis ? 32'd0 : 32'(stalls + 1));

    if (!mis) begin
      if (we) begin
        ref_mem[addr[5:2]] = (ref_mem[addr[5:2]] & ~(mask << sh)) | ((wd << sh) & (mask << sh));
      end else begin
        w = ref_mem[addr[5:2]];
        v = (w >> sh) & mask;
        if (sgn && n < 4 && v[8*n-1]) v = v | ~mask;
        last_rdata = v;
      end
    end
    chk("core_rdata", core_rdata, last_rdata);
    chk("mem_word", mem[addr[5:2]], ref_mem[addr[5:2]]);

    @(negedge clk);
    chk("busy_after", 32'(core_busy), 32'd0);
    chk("done_after", 32'(core_done), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_busy", 32'(core_busy), 32'd0);
    chk("rst_done", 32'(core_done), 32'd0);
    chk("rst_err", 32'(core_err), 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    chk("rst_rdata", core_rdata, 32'd0);
    chk("rst_be", 32'(byteenable), 32'd0);
    reset = 1'b0;

    // Fill memory through the bus so model and slave agree
    for (int i = 0; i < 16; i++)
      do_txn(1, 32'hBFC0_0000 | 32'(i * 4), 2'b10, 0, $urandom, 0);

    // Directed cases
    do_txn(1, 32'hBFC0_0030, 2'b10, 0, 32'h1234_5678, 0);
    do_txn(1, 32'hBFC0_0032, 2'b00, 0, 32'h0000_00AB, 0);
    do_txn(1, 32'hBFC0_0020, 2'b10, 0, 32'h8081_F0F7, 0);
    do_txn(0, 32'hBFC0_0020, 2'b00, 1, 32'h0, 0);
    chk("ld_sbyte", core_rdata, 32'hFFFF_FFF7);
    do_txn(0, 32'hBFC0_0022, 2'b01, 0, 32'h0, 0);
    chk("ld_uhalf", core_rdata, 32'h0000_8081);
    do_txn(0, 32'hBFC0_0022, 2'b01, 1, 32'h0, 0);
    chk("ld_shalf", core_rdata, 32'hFFFF_8081);
    do_txn(0, 32'hBFC0_0020, 2'b10, 1, 32'h0, 3);
    chk("ld_word_stall", core_rdata, 32'h8081_F0F7);
    do_txn(0, 32'hBFC0_0002, 2'b10, 0, 32'h0, 0);
    do_txn(0, 32'hBFC0_0021, 2'b01, 1, 32'h0, 0);
    do_txn(1, 32'hBFC0_0023, 2'b11, 0, 32'hDEAD_BEEF, 0);

    // Reset while a stalled read sits in BUS
    @(negedge clk);
    stall_cfg = 10;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'hBFC0_0010; core_size = 2'b10;
    @(posedge clk);
    #1 core_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("stalled_read", 32'(read), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_read", 32'(read), 32'd0);
    chk("abort_busy", 32'(core_busy), 32'd0);
    chk("abort_done", 32'(core_done), 32'd0);
    reset = 1'b0;
    last_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", 32'(core_done | read | write), 32'd0);
    end
    do_txn(0, 32'hBFC0_0030, 2'b10, 0, 32'h0, 1);
    chk("post_reset_load", core_rdata, 32'h12AB_5678);

    // Randomized traffic
    for (int i = 0; i < 80; i++)
      do_txn(bit'($urandom_range(0, 1)), 32'hBFC0_0000 | 32'($urandom_range(0, 63)),
             2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), $urandom,
             int'($urandom_range(0, 3)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
